bp_be_ptw_miss_arb: RTL and testbench

BP_BE_PTW_MISS_ARB -- requirements
Module: bp_be_ptw_miss_arb

---
 rtl/bp_be_pkg.sv | 42 ++++
 rtl/bp_be_ptw_miss_slot.sv | 45 ++++
 rtl/bp_be_ptw_miss_arb.sv | 167 ++++++++++++++++
 tb/tb_bp_be_ptw_miss_arb.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Back-end PTW arbitration types: miss/fill packets, arbiter state and config helpers.
// Optional feature macro used by bp_be_ptw_miss_arb: BP_BE_PTW_ARB_PERF_EN.
package bp_be_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  localparam int bp_vaddr_width_gp = 39;

  function automatic int vaddr_width_f(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 39;
      default:          return 39;
    endcase
  endfunction

  typedef struct packed {
    logic                         instr_miss_v;
    logic                         load_miss_v;
    logic                         store_miss_v;
    logic [bp_vaddr_width_gp-1:0] vaddr;
  } bp_be_ptw_miss_pkt_s;

  typedef struct packed {
    logic v;
    logic instr_page_fault_v;
    logic load_page_fault_v;
    logic store_page_fault_v;
  } bp_be_ptw_fill_pkt_s;

  typedef enum logic [1:0] {
    eIdle = 2'd0,
    eWalk = 2'd1,
    eResp = 2'd2
  } bp_be_ptw_arb_state_e;

  function automatic logic [31:0] sat_inc_f(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/bp_be_ptw_miss_slot.sv
// One pending-miss holding register (valid, vaddr, store) with set and clear.
module bp_be_ptw_miss_slot #(
  parameter int vaddr_width_p = 39
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     set_i,
  input  logic                     clr_i,
  input  logic [vaddr_width_p-1:0] vaddr_i,
  input  logic                     store_i,
  output logic                     v_o,
  output logic [vaddr_width_p-1:0] vaddr_o,
  output logic                     store_o
);

  logic                     r_v;
  logic [vaddr_width_p-1:0] r_vaddr;
  logic                     r_store;

  // Clear wins over set; the arbiter never asserts both on the same slot.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_v     <= 1'b0;
      r_vaddr <= '0;
      r_store <= 1'b0;
    end else if (clr_i) begin
      r_v     <= 1'b0;
      r_vaddr <= r_vaddr;
      r_store <= r_store;
    end else if (set_i) begin
      r_v     <= 1'b1;
      r_vaddr <= vaddr_i;
      r_store <= store_i;
    end else begin
      r_v     <= r_v;
      r_vaddr <= r_vaddr;
      r_store <= r_store;
    end
  end

  assign v_o     = r_v;
  assign vaddr_o = r_vaddr;
  assign store_o = r_store;

endmodule

// File: rtl/bp_be_ptw_miss_arb.sv
// Arbitrates ITLB/DTLB misses onto a single page-table walker, one walk at a time.
// Define BP_BE_PTW_ARB_PERF_EN to add saturating performance counters on perf_cnt_o.
module bp_be_ptw_miss_arb
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  localparam int vaddr_width_p = vaddr_width_f(bp_params_p)
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic                                     flush_i,
  input  logic                                     itlb_miss_v_i,
  input  logic [vaddr_width_p-1:0]                 itlb_miss_vaddr_i,
  output logic                                     itlb_miss_ready_o,
  input  logic                                     dtlb_miss_v_i,
  input  logic                                     dtlb_miss_store_i,
  input  logic [vaddr_width_p-1:0]                 dtlb_miss_vaddr_i,
  output logic                                     dtlb_miss_ready_o,
  output logic [$bits(bp_be_ptw_miss_pkt_s)-1:0]   ptw_miss_pkt_o,
  input  logic                                     ptw_busy_i,
  input  logic [$bits(bp_be_ptw_fill_pkt_s)-1:0]   ptw_fill_pkt_i,
  output logic                                     itlb_resp_v_o,
  output logic                                     dtlb_resp_v_o,
  output logic                                     resp_fault_o,
  output logic                                     busy_o
`ifdef BP_BE_PTW_ARB_PERF_EN
  , output logic [3:0][31:0]                       perf_cnt_o
`endif
);

  bp_be_ptw_arb_state_e r_state, w_state_n;
  logic                 r_last_dtlb;
  logic                 r_fault;
  logic                 r_poison;

  logic                     w_itlb_v, w_dtlb_v;
  logic                     w_itlb_store, w_dtlb_store;
  logic [vaddr_width_p-1:0] w_itlb_vaddr, w_dtlb_vaddr;
  logic                     w_itlb_set, w_dtlb_set, w_itlb_clr, w_dtlb_clr;
  logic                     w_issue, w_pick_dtlb, w_sel_store, w_resp, w_in_flight;
  bp_be_ptw_fill_pkt_s      w_fill;
  bp_be_ptw_miss_pkt_s      w_pkt;

  assign w_fill      = ptw_fill_pkt_i;
  assign w_in_flight = (r_state != eIdle);

  assign itlb_miss_ready_o = ~w_itlb_v & ~flush_i;
  assign dtlb_miss_ready_o = ~w_dtlb_v & ~flush_i;
  assign w_itlb_set        = itlb_miss_v_i & itlb_miss_ready_o;
  assign w_dtlb_set        = dtlb_miss_v_i & dtlb_miss_ready_o;

  // r_last_dtlb doubles as the in-flight owner: it is updated only on issue.
  assign w_itlb_clr = (flush_i & ~(w_in_flight & ~r_last_dtlb))
                    | ((r_state == eResp) & ~r_last_dtlb);
  assign w_dtlb_clr = (flush_i & ~(w_in_flight & r_last_dtlb))
                    | ((r_state == eResp) & r_last_dtlb);

  bp_be_ptw_miss_slot #(.vaddr_width_p(vaddr_width_p)) u_itlb_slot (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .set_i   (w_itlb_set),
    .clr_i   (w_itlb_clr),
    .vaddr_i (itlb_miss_vaddr_i),
    .store_i (1'b0),
    .v_o     (w_itlb_v),
    .vaddr_o (w_itlb_vaddr),
    .store_o (w_itlb_store)
  );

  bp_be_ptw_miss_slot #(.vaddr_width_p(vaddr_width_p)) u_dtlb_slot (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .set_i   (w_dtlb_set),
    .clr_i   (w_dtlb_clr),
    .vaddr_i (dtlb_miss_vaddr_i),
    .store_i (dtlb_miss_store_i),
    .v_o     (w_dtlb_v),
    .vaddr_o (w_dtlb_vaddr),
    .store_o (w_dtlb_store)
  );

  assign w_issue     = (r_state == eIdle) & ~ptw_busy_i & ~flush_i & (w_itlb_v | w_dtlb_v);
  assign w_pick_dtlb = w_dtlb_v & (~w_itlb_v | ~r_last_dtlb);
  assign w_sel_store = w_pick_dtlb ? w_dtlb_store : w_itlb_store;
  assign w_resp      = (r_state == eResp) & ~r_poison & ~flush_i;

  // Next-state decode.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      eIdle: begin
        if (w_issue) w_state_n = eWalk;
        else         w_state_n = eIdle;
      end
      eWalk: begin
        if (w_fill.v) w_state_n = eResp;
        else          w_state_n = eWalk;
      end
      eResp:   w_state_n = eIdle;
      default: w_state_n = eIdle;
    endcase
  end

  // State, grant owner, captured fault and flush poison.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= eIdle;
      r_last_dtlb <= 1'b1;
      r_fault     <= 1'b0;
      r_poison    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (w_issue) r_last_dtlb <= w_pick_dtlb;
      else         r_last_dtlb <= r_last_dtlb;
      if ((r_state == eWalk) & w_fill.v)
        r_fault <= w_fill.instr_page_fault_v | w_fill.load_page_fault_v
                 | w_fill.store_page_fault_v;
      else
        r_fault <= r_fault;
      if (r_state == eResp)                    r_poison <= 1'b0;
      else if (flush_i & (r_state == eWalk))   r_poison <= 1'b1;
      else                                     r_poison <= r_poison;
    end
  end

  // Single-cycle miss packet, only in the issue cycle.
  always_comb begin
    w_pkt = '0;
    if (w_issue) begin
      w_pkt.instr_miss_v = ~w_pick_dtlb;
      w_pkt.load_miss_v  = w_pick_dtlb & ~w_sel_store;
      w_pkt.store_miss_v = w_sel_store;
      w_pkt.vaddr        = w_pick_dtlb ? w_dtlb_vaddr : w_itlb_vaddr;
    end else begin
      w_pkt = '0;
    end
  end

  assign ptw_miss_pkt_o = w_pkt;
  assign itlb_resp_v_o  = w_resp & ~r_last_dtlb;
  assign dtlb_resp_v_o  = w_resp & r_last_dtlb;
  assign resp_fault_o   = w_resp & r_fault;
  assign busy_o         = w_in_flight | w_itlb_v | w_dtlb_v;

`ifdef BP_BE_PTW_ARB_PERF_EN
  logic [3:0][31:0] r_perf;

  // Counters: [0] ITLB issues, [1] DTLB issues, [2] faults delivered, [3] flushed walks.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_perf <= '0;
    end else begin
      if (w_issue & ~w_pick_dtlb) r_perf[0] <= sat_inc_f(r_perf[0]);
      else                        r_perf[0] <= r_perf[0];
      if (w_issue & w_pick_dtlb)  r_perf[1] <= sat_inc_f(r_perf[1]);
      else                        r_perf[1] <= r_perf[1];
      if (w_resp & r_fault)       r_perf[2] <= sat_inc_f(r_perf[2]);
      else                        r_perf[2] <= r_perf[2];
      if (flush_i & (r_state == eWalk) & ~r_poison) r_perf[3] <= sat_inc_f(r_perf[3]);
      else                                          r_perf[3] <= r_perf[3];
    end
  end

  assign perf_cnt_o = r_perf;
`endif

endmodule

// File: tb/tb_bp_be_ptw_miss_arb.sv
// Bench for bp_be_ptw_miss_arb: vector table plus hand-written flush/busy/reset sequences.
module tb_bp_be_ptw_miss_arb;
  import bp_be_pkg::*;

  logic        clk;
  logic        reset_i, flush_i, ptw_busy_i;
  logic        itlb_miss_v_i, dtlb_miss_v_i, dtlb_miss_store_i;
  logic [38:0] itlb_miss_vaddr_i, dtlb_miss_vaddr_i;
  logic        itlb_miss_ready_o, dtlb_miss_ready_o;
  logic [$bits(bp_be_ptw_miss_pkt_s)-1:0] ptw_miss_pkt_o;
  bp_be_ptw_miss_pkt_s mpkt;
  bp_be_ptw_fill_pkt_s fill_s;
  logic        itlb_resp_v_o, dtlb_resp_v_o, resp_fault_o, busy_o;
`ifdef BP_BE_PTW_ARB_PERF_EN
  logic [3:0][31:0] perf_cnt_o;
`endif

  bp_be_ptw_miss_arb dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .flush_i           (flush_i),
    .itlb_miss_v_i     (itlb_miss_v_i),
    .itlb_miss_vaddr_i (itlb_miss_vaddr_i),
    .itlb_miss_ready_o (itlb_miss_ready_o),
    .dtlb_miss_v_i     (dtlb_miss_v_i),
    .dtlb_miss_store_i (dtlb_miss_store_i),
    .dtlb_miss_vaddr_i (dtlb_miss_vaddr_i),
    .dtlb_miss_ready_o (dtlb_miss_ready_o),
    .ptw_miss_pkt_o    (ptw_miss_pkt_o),
    .ptw_busy_i        (ptw_busy_i),
    .ptw_fill_pkt_i    (fill_s),
    .itlb_resp_v_o     (itlb_resp_v_o),
    .dtlb_resp_v_o     (dtlb_resp_v_o),
    .resp_fault_o      (resp_fault_o),
    .busy_o            (busy_o)
`ifdef BP_BE_PTW_ARB_PERF_EN
    , .perf_cnt_o      (perf_cnt_o)
`endif
  );

  assign mpkt = ptw_miss_pkt_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        i;
    logic        l;
    logic        s;
    logic [38:0] va;
  } exp_pkt_t;

  typedef struct packed {
    logic dtlb;
    logic fault;
  } exp_resp_t;

  exp_pkt_t  q_pkt[$];
  exp_resp_t q_resp[$];

  typedef struct {
    int          src;
    logic [38:0] va;
    int          walk;
    logic [2:0]  flt;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (mpkt.instr_miss_v | mpkt.load_miss_v | mpkt.store_miss_v) begin
      if (q_pkt.size() == 0) begin
        chk("unexpected_pkt", {mpkt.instr_miss_v, mpkt.load_miss_v, mpkt.store_miss_v}, 64'd0);
      end else begin
        exp_pkt_t e;
        e = q_pkt.pop_front();
        chk("pkt_flags", {mpkt.instr_miss_v, mpkt.load_miss_v, mpkt.store_miss_v}, {e.i, e.l, e.s});
        chk("pkt_vaddr", mpkt.vaddr, e.va);
      end
    end
    if (itlb_resp_v_o | dtlb_resp_v_o) begin
      if (q_resp.size() == 0) begin
        chk("unexpected_resp", {itlb_resp_v_o, dtlb_resp_v_o, resp_fault_o}, 64'd0);
      end else begin
        exp_resp_t r;
        r = q_resp.pop_front();
        chk("resp", {itlb_resp_v_o, dtlb_resp_v_o, resp_fault_o}, {~r.dtlb, r.dtlb, r.fault});
      end
    end
  end

  task automatic push_pkt(input int src, input logic [38:0] va);
    exp_pkt_t e;
    e.i  = (src == 0);
    e.l  = (src == 1);
    e.s  = (src == 2);
    e.va = va;
    q_pkt.push_back(e);
  endtask

  task automatic drive_miss(input int src, input logic [38:0] va, input bit expect_issue);
    if (src == 0) begin
      chk("itlb_ready_pre", itlb_miss_ready_o, 64'd1);
      itlb_miss_v_i     = 1'b1;
      itlb_miss_vaddr_i = va;
    end else begin
      chk("dtlb_ready_pre", dtlb_miss_ready_o, 64'd1);
      dtlb_miss_v_i     = 1'b1;
      dtlb_miss_store_i = (src == 2);
      dtlb_miss_vaddr_i = va;
    end
    if (expect_issue) push_pkt(src, va);
    tick();
    itlb_miss_v_i = 1'b0;
    dtlb_miss_v_i = 1'b0;
  endtask

  task automatic do_fill(input logic [2:0] flt, input bit exp_resp, input bit exp_dtlb, input bit exp_fault);
    exp_resp_t r;
    fill_s.v                  = 1'b1;
    fill_s.instr_page_fault_v = flt[2];
    fill_s.load_page_fault_v  = flt[1];
    fill_s.store_page_fault_v = flt[0];
    if (exp_resp) begin
      r.dtlb  = exp_dtlb;
      r.fault = exp_fault;
      q_resp.push_back(r);
    end
    tick();
    fill_s = '0;
  endtask

  task automatic wait_pkt(input int left);
    int t = 0;
    while (q_pkt.size() > left && t < 40) begin
      tick();
      t++;
    end
    if (q_pkt.size() > left) chk("pkt_timeout", q_pkt.size(), left);
  endtask

  task automatic wait_resp(input int left);
    int t = 0;
    while (q_resp.size() > left && t < 40) begin
      tick();
      t++;
    end
    if (q_resp.size() > left) chk("resp_timeout", q_resp.size(), left);
  endtask

  initial begin
    vecs[0] = '{src: 0, va: 39'h40_0000_1000, walk: 5, flt: 3'b000, exp_fault: 1'b0};
    vecs[1] = '{src: 1, va: 39'h12_3456_7000, walk: 2, flt: 3'b010, exp_fault: 1'b1};
    vecs[2] = '{src: 2, va: 39'h7F_FFFF_F000, walk: 0, flt: 3'b001, exp_fault: 1'b1};
    vecs[3] = '{src: 0, va: 39'h00_0000_0000, walk: 1, flt: 3'b100, exp_fault: 1'b1};
    vecs[4] = '{src: 1, va: 39'h55_AAAA_5000, walk: 3, flt: 3'b001, exp_fault: 1'b1};
    vecs[5] = '{src: 2, va: 39'h01_0000_0000, walk: 0, flt: 3'b000, exp_fault: 1'b0};

    reset_i = 1'b1; flush_i = 1'b0; ptw_busy_i = 1'b0;
    itlb_miss_v_i = 1'b0; dtlb_miss_v_i = 1'b0; dtlb_miss_store_i = 1'b0;
    itlb_miss_vaddr_i = '0; dtlb_miss_vaddr_i = '0; fill_s = '0;
    #2;
    chk("rst_busy", busy_o, 64'd0);
    chk("rst_pkt", ptw_miss_pkt_o, 64'd0);
    chk("rst_resp", {itlb_resp_v_o, dtlb_resp_v_o, resp_fault_o}, 64'd0);
    tick(); tick();
    reset_i = 1'b0;
    #1;
    chk("rst_ready", {itlb_miss_ready_o, dtlb_miss_ready_o}, 64'd3);

    // Single misses from the table.
    for (int k = 0; k < 6; k++) begin
      drive_miss(vecs[k].src, vecs[k].va, 1'b1);
      wait_pkt(0);
      repeat (vecs[k].walk) tick();
      do_fill(vecs[k].flt, 1'b1, (vecs[k].src != 0), vecs[k].exp_fault);
      wait_resp(0);
      if (vecs[k].src == 0) chk("itlb_ready_post", itlb_miss_ready_o, 64'd1);
      else                  chk("dtlb_ready_post", dtlb_miss_ready_o, 64'd1);
      chk("busy_post", busy_o, 64'd0);
    end

    // Tie after a DTLB grant: ITLB first, then DTLB store.
    chk("tie_ready", {itlb_miss_ready_o, dtlb_miss_ready_o}, 64'd3);
    itlb_miss_v_i = 1'b1; itlb_miss_vaddr_i = 39'h11_0000_1000;
    dtlb_miss_v_i = 1'b1; dtlb_miss_store_i = 1'b1; dtlb_miss_vaddr_i = 39'h22_0000_2000;
    push_pkt(0, 39'h11_0000_1000);
    push_pkt(2, 39'h22_0000_2000);
    tick();
    itlb_miss_v_i = 1'b0; dtlb_miss_v_i = 1'b0;
    wait_pkt(1);
    chk("tie_dtlb_held", dtlb_miss_ready_o, 64'd0);
    do_fill(3'b000, 1'b1, 1'b0, 1'b0);
    wait_resp(0);
    wait_pkt(0);
    do_fill(3'b000, 1'b1, 1'b1, 1'b0);
    wait_resp(0);

    // ITLB alone, then a tie: DTLB must win this time.
    drive_miss(0, 39'h33_0000_3000, 1'b1);
    wait_pkt(0);
    do_fill(3'b000, 1'b1, 1'b0, 1'b0);
    wait_resp(0);
    itlb_miss_v_i = 1'b1; itlb_miss_vaddr_i = 39'h44_0000_4000;
    dtlb_miss_v_i = 1'b1; dtlb_miss_store_i = 1'b0; dtlb_miss_vaddr_i = 39'h55_0000_5000;
    push_pkt(1, 39'h55_0000_5000);
    push_pkt(0, 39'h44_0000_4000);
    tick();
    itlb_miss_v_i = 1'b0; dtlb_miss_v_i = 1'b0;
    wait_pkt(1);
    do_fill(3'b000, 1'b1, 1'b1, 1'b0);
    wait_resp(0);
    wait_pkt(0);
    do_fill(3'b100, 1'b1, 1'b0, 1'b1);
    wait_resp(0);

    // Flush beats a same-cycle miss in idle.
    itlb_miss_v_i = 1'b1; itlb_miss_vaddr_i = 39'h66_0000_6000; flush_i = 1'b1;
    #1;
    chk("flush_ready_low", itlb_miss_ready_o, 64'd0);
    tick();
    itlb_miss_v_i = 1'b0; flush_i = 1'b0;
    repeat (3) tick();
    chk("flush_no_accept_busy", busy_o, 64'd0);

    // Flush during a DTLB walk with an ITLB miss pending.
    drive_miss(1, 39'h77_0000_7000, 1'b1);
    wait_pkt(0);
    chk("walk_dtlb_held", dtlb_miss_ready_o, 64'd0);
    drive_miss(0, 39'h08_0000_8000, 1'b0);
    chk("pend_itlb_full", itlb_miss_ready_o, 64'd0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    chk("flush_itlb_freed", itlb_miss_ready_o, 64'd1);
    chk("flush_dtlb_still_held", dtlb_miss_ready_o, 64'd0);
    chk("flush_walk_busy", busy_o, 64'd1);
    repeat (2) tick();
    do_fill(3'b010, 1'b0, 1'b1, 1'b1);
    repeat (3) tick();
    chk("flush_done_busy", busy_o, 64'd0);
    chk("flush_done_ready", {itlb_miss_ready_o, dtlb_miss_ready_o}, 64'd3);

    // PTW busy holds off issue.
    ptw_busy_i = 1'b1;
    drive_miss(0, 39'h09_0000_9000, 1'b0);
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c == 9) chk("ptwbusy_hold_busy", busy_o, 64'd1);
    end
    push_pkt(0, 39'h09_0000_9000);
    ptw_busy_i = 1'b0;
    wait_pkt(0);
    do_fill(3'b000, 1'b1, 1'b0, 1'b0);
    wait_resp(0);

    // Asynchronous reset in the middle of a walk, then a stray fill.
    drive_miss(2, 39'h0A_0000_A000, 1'b1);
    wait_pkt(0);
    #2 reset_i = 1'b1;
    #1;
    chk("amid_rst_busy", busy_o, 64'd0);
    chk("amid_rst_pkt", ptw_miss_pkt_o, 64'd0);
    chk("amid_rst_resp", {itlb_resp_v_o, dtlb_resp_v_o, resp_fault_o}, 64'd0);
    tick();
    reset_i = 1'b0;
    do_fill(3'b001, 1'b0, 1'b1, 1'b1);
    repeat (3) tick();
    chk("stray_fill_busy", busy_o, 64'd0);

    chk("pkt_queue_empty", q_pkt.size(), 64'd0);
    chk("resp_queue_empty", q_resp.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
